// File: rtl/calc_pkg.sv
// calc_pkg: shared state encodings, op-code layout and width defaults for the calculator control path
package calc_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int RES_W_DEF = 32;
   localparam int OP_W = 3;
   localparam int OP_UNARY_BIT = 2;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD_B = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT_CORE = 3'd3,
      ST_CONVERT = 3'd4,
      ST_SHOW = 3'd5,
      ST_ERROR = 3'd6
   } state_e;
   function automatic logic is_unary(input logic [OP_W-1:0] op);
      return op[OP_UNARY_BIT];
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle rising-edge pulse for a raw button
module btn_debounce #(
   parameter int DBNC_CYC = 250000
) (
   input logic clk,
   input logic reset_n,
   input logic btn_i,
   output logic pulse_o
);
   localparam int CW = $clog2(DBNC_CYC + 1);
   logic [1:0] sync_q;
   logic level_q, pulse_q, differs, settled;
   logic [CW-1:0] cnt_q;
   assign differs = sync_q[1] != level_q;
   assign settled = cnt_q == CW'(DBNC_CYC - 1);
   assign pulse_o = pulse_q;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         cnt_q <= (differs && !settled) ? cnt_q + CW'(1) : '0;
         level_q <= (differs && settled) ? sync_q[1] : level_q;
         pulse_q <= differs && settled && sync_q[1];
      end
   end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand entry, core start/timeout supervision and BCD hand-off for the calculator
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W = RES_W_DEF,
   parameter int DBNC_CYC = 250000,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic clk,
   input logic reset_n,
   input logic btn_exec,
   input logic [DATA_W-1:0] switch_data,
   input logic [OP_W-1:0] op_select,
   output logic core_start,
   output logic [DATA_W-1:0] core_operand_a,
   output logic [DATA_W-1:0] core_operand_b,
   output logic [OP_W-1:0] core_op,
   input logic core_ready,
   input logic [RES_W-1:0] core_result,
   output logic bcd_start,
   output logic [15:0] bcd_bin,
   input logic bcd_done,
   output logic result_valid,
   output logic overflow,
   output logic timeout_err,
   output logic [2:0] state_code
);
   localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
   state_e state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [15:0] bin_q, bin_d;
   logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
   logic bcd_start_q, bcd_start_d, valid_q, valid_d, ovf_q, ovf_d, tmo_q, tmo_d;
   logic exec_pulse;
   btn_debounce #(.DBNC_CYC(DBNC_CYC)) u_dbnc (
      .clk(clk),
      .reset_n(reset_n),
      .btn_i(btn_exec),
      .pulse_o(exec_pulse)
   );
   // timer counts cycles since core_start and saturates at the expiry value
   assign tmr_inc = (tmr_q == T_MAX) ? tmr_q : tmr_q + TW'(1);
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         bin_q <= '0;
         tmr_q <= '0;
         bcd_start_q <= 1'b0;
         valid_q <= 1'b0;
         ovf_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         bin_q <= bin_d;
         tmr_q <= tmr_d;
         bcd_start_q <= bcd_start_d;
         valid_q <= valid_d;
         ovf_q <= ovf_d;
         tmo_q <= tmo_d;
      end
   end
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      bin_d = bin_q;
      tmr_d = '0;
      bcd_start_d = 1'b0;
      valid_d = valid_q;
      ovf_d = ovf_q;
      tmo_d = tmo_q;
      case (state_q)
         ST_IDLE: if (exec_pulse) begin
            a_d = switch_data;
            op_d = op_select;
            b_d = is_unary(op_select) ? '0 : b_q;
            state_d = is_unary(op_select) ? ST_ISSUE : ST_LOAD_B;
         end
         ST_LOAD_B: if (exec_pulse) begin
            b_d = switch_data;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            tmr_d = tmr_inc;
            state_d = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            tmr_d = tmr_inc;
            if (core_ready) begin
               ovf_d = |core_result[RES_W-1:16];
               bin_d = ovf_d ? bin_q : core_result[15:0];
               bcd_start_d = !ovf_d;
               state_d = ovf_d ? ST_ERROR : ST_CONVERT;
            end else if (tmr_q == T_MAX) begin
               tmo_d = 1'b1;
               state_d = ST_ERROR;
            end
         end
         ST_CONVERT: if (bcd_done) begin
            valid_d = 1'b1;
            state_d = ST_SHOW;
         end
         ST_SHOW: if (exec_pulse) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
         ST_ERROR: if (exec_pulse) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   assign core_start = state_q == ST_ISSUE;
   assign core_operand_a = a_q;
   assign core_operand_b = b_q;
   assign core_op = op_q;
   assign bcd_start = bcd_start_q;
   assign bcd_bin = bin_q;
   assign result_valid = valid_q;
   assign overflow = ovf_q;
   assign timeout_err = tmo_q;
   assign state_code = state_q;
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control sequencer for the calculator datapath. It turns a raw execute button into a two-operand entry sequence, issues one start pulse to the arithmetic core, and supervises the core with a timeout.
- It routes the low 16 bits of the result to the binary-to-BCD converter and holds result/error status for the display and LED logic.
- It sits between the user inputs (switches, button) and the core/converter pair, and replaces ad-hoc start gating in the top level.

Parameters:
- DATA_W, 16, operand width.
- RES_W, 32, core result width.
- DBNC_CYC, 250000, cycles the synchronized button must be stable before it is accepted.
- TIMEOUT_CYC, 4096, maximum cycles from core_start to core_ready.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset: synchronous, active-low.
- btn_exec  in  1  raw execute button, asynchronous.
- switch_data  in  DATA_W  operand value from switches.
- op_select  in  3  operation code.
- core_start  out  1  one-cycle start pulse to the core.
- core_operand_a  out  DATA_W  latched operand A.
- core_operand_b  out  DATA_W  latched operand B (0 for unary ops).
- core_op  out  3  latched operation code.
- core_ready  in  1  core completion, sampled while waiting.
- core_result  in  RES_W  core result, valid when core_ready=1.
- bcd_start  out  1  one-cycle start pulse to the BCD converter.
- bcd_bin  out  16  binary value presented to the converter.
- bcd_done  in  1  conversion complete.
- result_valid  out  1  BCD result displayable.
- overflow  out  1  result exceeds 16 bits.
- timeout_err  out  1  core did not respond in time.
- state_code  out  3  current FSM state, for LEDs.

Behaviour:
- Reset values (synchronous, reset_n=0): all outputs 0, state IDLE, timers 0. Reset mid-operation aborts immediately with no further core_start/bcd_start pulses.
- Button path: 2-FF synchronizer, then a stability counter.
  - The debounced level updates after DBNC_CYC consecutive equal samples.
  - Rising edge of the debounced level gives exec_pulse (1 cycle).
  - Exactly one pulse per press; bounces shorter than DBNC_CYC produce none.
- States (state_code): IDLE=0, LOAD_B=1, ISSUE=2, WAIT_CORE=3, CONVERT=4, SHOW=5, ERROR=6.
- IDLE: on exec_pulse, latch core_operand_a=switch_data and core_op=op_select.
  - If op_select[2]=1 (unary ops 4..7): core_operand_b=0, go to ISSUE.
  - Otherwise go to LOAD_B.
- LOAD_B: on exec_pulse, latch core_operand_b=switch_data, go to ISSUE.
- ISSUE: core_start=1 for exactly this cycle, timeout counter cleared, go to WAIT_CORE.
  - Latency: 1 cycle after the operand-accepting edge.
- WAIT_CORE: counter increments each cycle.
  - core_ready=1: latch result.
    - If core_result[RES_W-1:16] != 0: set overflow, go to ERROR.
    - Else: bcd_bin=core_result[15:0], bcd_start=1 (one cycle), go to CONVERT.
  - Counter == TIMEOUT_CYC-1 with no ready: set timeout_err, go to ERROR.
  - core_ready and expiry in the same cycle: ready wins.
- CONVERT: on bcd_done, set result_valid=1, go to SHOW. No timeout; the converter is fixed-latency.
- SHOW: outputs held stable. On exec_pulse: clear result_valid, go to IDLE. The same press does not also capture operand A.
- ERROR: flags held. On exec_pulse: clear overflow and timeout_err, go to IDLE.
- exec_pulse is ignored in ISSUE, WAIT_CORE and CONVERT.
- core_ready is ignored outside WAIT_CORE; bcd_done is ignored outside CONVERT.
- core_operand_a, core_operand_b and core_op are stable from ISSUE until the next IDLE/LOAD_B capture.
- The timeout counter is ceil(log2(TIMEOUT_CYC)) bits wide and does not wrap; it saturates and triggers the error.

Decomposition:
- Package calc_pkg holds:
  - State encodings.
  - Op-code constants (unary flag = bit 2).
  - DATA_W/RES_W defaults.
- Sub-module btn_debounce (2-FF sync + stability counter + rising-edge pulse), parameterized by DBNC_CYC. It is reusable for future buttons.

Test Plan:
- All tests use DBNC_CYC=4 and TIMEOUT_CYC=16.
- Binary op: A=25, op=0, press; B=17, press → exactly one core_start with a=25, b=17, op=0. Model ready after 3 cycles with result 42 → bcd_start once, bcd_bin=42. bcd_done → result_valid=1, state_code=5.
- Unary op: A=9, op=4, press → ISSUE without a second press, core_operand_b=0, single core_start.
- Overflow: model returns 32'h0001_0000 → overflow=1, state_code=6, no bcd_start. Next press → overflow=0, IDLE.
- Timeout: core_ready never asserted → timeout_err=1 exactly 16 cycles after core_start. Ready asserted on the expiry cycle in a second run → normal path, timeout_err=0.
- Bounce: btn toggles every 2 cycles for 20 cycles, then held high → exactly one exec_pulse. Presses during WAIT_CORE are ignored (operands unchanged).
- Reset mid-op: reset_n=0 during WAIT_CORE → next cycle all outputs 0, IDLE, no core_start. A later ready pulse is ignored.
